// File: rtl/cmd_desc_writer.sv
// cmd_desc_writer: write-back side of a DMA channel's command-link descriptor.
// When start is accepted, the writer captures the header, the base address and
// the register snapshot. It then streams the header word and one payload word
// for each set header bit in 1..31, in ascending bit order.
// Ports:
//   clk, resetn             clock, asynchronous active-low reset
//   start, abort            request a descriptor / cancel the one in flight
//   header_in, base_addr    descriptor header and byte address (bits[1:0] dropped)
//   reg_snapshot            13 packed channel registers, word k at [WIDTH*k +: WIDTH]
//   wr_ready                downstream accepts the presented beat
//   wr_valid/addr/data/last beat being presented (all registered)
//   busy, done, aborted     status; done/aborted are one-cycle pulses
//   beat_cnt                beats accepted in the current or most recent descriptor
module cmd_desc_writer #(
  parameter int unsigned WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  start,
  input  logic                  abort,
  input  logic [31:0]           header_in,
  input  logic [31:0]           base_addr,
  input  logic [WIDTH*13-1:0]   reg_snapshot,
  input  logic                  wr_ready,
  output logic                  wr_valid,
  output logic [31:0]           wr_addr,
  output logic [WIDTH-1:0]      wr_data,
  output logic                  wr_last,
  output logic                  busy,
  output logic                  done,
  output logic                  aborted,
  output logic [5:0]            beat_cnt
);

  localparam int unsigned NREGS  = 13;
  localparam int unsigned SNAP_W = WIDTH * NREGS;

  typedef enum logic [1:0] {S_IDLE, S_HDR, S_PAYLOAD, S_DONE} state_e;

  state_e              state_q, state_d;
  logic [30:0]         mask_q, mask_d;        // pending header bits 31..1
  logic [SNAP_W-1:0]   snap_q, snap_d;
  logic [31:0]         wr_addr_q, wr_addr_d;
  logic [WIDTH-1:0]    wr_data_q, wr_data_d;
  logic                wr_valid_q, wr_valid_d;
  logic                wr_last_q, wr_last_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                aborted_q, aborted_d;
  logic [5:0]          beat_cnt_q, beat_cnt_d;

  logic                hs;
  logic [30:0]         mask_clr;

  // Header bit position (1..31) of the lowest pending mask bit.
  function automatic logic [4:0] low_bit(input logic [30:0] m);
    logic [4:0] r;
    r = 5'd0;
    for (int i = 30; i >= 0; i--) begin
      if (m[i]) r = 5'(i + 1);
    end
    return r;
  endfunction

  // Payload word for a header bit; unmapped bits send zero to keep the reader aligned.
  function automatic logic [WIDTH-1:0] map_word(input logic [4:0] b,
                                                input logic [SNAP_W-1:0] s);
    logic [WIDTH-1:0] w;
    w = '0;
    case (b)
      5'd2:    w = s[WIDTH*0  +: WIDTH];
      5'd3:    w = s[WIDTH*1  +: WIDTH];
      5'd4:    w = s[WIDTH*2  +: WIDTH];
      5'd6:    w = s[WIDTH*3  +: WIDTH];
      5'd8:    w = s[WIDTH*4  +: WIDTH];
      5'd10:   w = s[WIDTH*5  +: WIDTH];
      5'd11:   w = s[WIDTH*6  +: WIDTH];
      5'd12:   w = s[WIDTH*7  +: WIDTH];
      5'd14:   w = s[WIDTH*8  +: WIDTH];
      5'd19:   w = s[WIDTH*9  +: WIDTH];
      5'd20:   w = s[WIDTH*10 +: WIDTH];
      5'd21:   w = s[WIDTH*11 +: WIDTH];
      5'd30:   w = s[WIDTH*12 +: WIDTH];
      default: w = '0;
    endcase
    return w;
  endfunction

  assign hs       = wr_valid_q & wr_ready;
  assign mask_clr = mask_q & (mask_q - 31'd1);

  // Next-state and registered-output logic.
  always_comb begin
    state_d    = state_q;
    mask_d     = mask_q;
    snap_d     = snap_q;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    wr_valid_d = wr_valid_q;
    wr_last_d  = wr_last_q;
    busy_d     = busy_q;
    beat_cnt_d = beat_cnt_q;
    done_d     = 1'b0;
    aborted_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d    = S_HDR;
          mask_d     = header_in[31:1];
          snap_d     = reg_snapshot;
          wr_addr_d  = {base_addr[31:2], 2'b00};
          wr_data_d  = WIDTH'(header_in);
          wr_valid_d = 1'b1;
          wr_last_d  = (header_in[31:1] == 31'd0);
          busy_d     = 1'b1;
          beat_cnt_d = 6'd0;
        end
      end
      S_HDR: begin
        if (hs) begin
          beat_cnt_d = beat_cnt_q + 6'd1;
          wr_addr_d  = wr_addr_q + 32'd4;
          if (mask_q != 31'd0) begin
            state_d   = S_PAYLOAD;
            wr_data_d = map_word(low_bit(mask_q), snap_q);
            wr_last_d = (mask_clr == 31'd0);
          end else begin
            state_d    = S_DONE;
            wr_valid_d = 1'b0;
            wr_last_d  = 1'b0;
            done_d     = 1'b1;
          end
        end
      end
      S_PAYLOAD: begin
        if (hs) begin
          beat_cnt_d = beat_cnt_q + 6'd1;
          wr_addr_d  = wr_addr_q + 32'd4;
          mask_d     = mask_clr;
          if (mask_clr != 31'd0) begin
            wr_data_d = map_word(low_bit(mask_clr), snap_q);
            wr_last_d = ((mask_clr & (mask_clr - 31'd1)) == 31'd0);
          end else begin
            state_d    = S_DONE;
            wr_valid_d = 1'b0;
            wr_last_d  = 1'b0;
            done_d     = 1'b1;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
      default: state_d = S_IDLE;
    endcase

    // Abort beats a same-cycle handshake; the accepted beat is still counted.
    if (abort && (state_q != S_IDLE)) begin
      state_d    = S_IDLE;
      wr_valid_d = 1'b0;
      wr_last_d  = 1'b0;
      busy_d     = 1'b0;
      done_d     = 1'b0;
      aborted_d  = 1'b1;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= S_IDLE;
      mask_q     <= '0;
      snap_q     <= '0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      wr_valid_q <= 1'b0;
      wr_last_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      aborted_q  <= 1'b0;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      mask_q     <= mask_d;
      snap_q     <= snap_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      wr_valid_q <= wr_valid_d;
      wr_last_q  <= wr_last_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      aborted_q  <= aborted_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

  assign wr_valid = wr_valid_q;
  assign wr_addr  = wr_addr_q;
  assign wr_data  = wr_data_q;
  assign wr_last  = wr_last_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign aborted  = aborted_q;
  assign beat_cnt = beat_cnt_q;

endmodule

// File: tb/tb_cmd_desc_writer.sv
// tb_cmd_desc_writer: random and directed descriptors checked against a
// reference model that builds each expected beat list from the header.
module tb_cmd_desc_writer;

  logic              clk;
  logic              resetn;
  logic              start;
  logic              abort;
  logic [31:0]       header_in;
  logic [31:0]       base_addr;
  logic [32*13-1:0]  reg_snapshot;
  logic              wr_ready;
  logic              wr_valid;
  logic [31:0]       wr_addr;
  logic [31:0]       wr_data;
  logic              wr_last;
  logic              busy;
  logic              done;
  logic              aborted;
  logic [5:0]        beat_cnt;

  int total = 0;
  int bad   = 0;

  cmd_desc_writer #(.WIDTH(32)) dut (
    .clk(clk), .resetn(resetn), .start(start), .abort(abort),
    .header_in(header_in), .base_addr(base_addr), .reg_snapshot(reg_snapshot),
    .wr_ready(wr_ready), .wr_valid(wr_valid), .wr_addr(wr_addr),
    .wr_data(wr_data), .wr_last(wr_last), .busy(busy), .done(done),
    .aborted(aborted), .beat_cnt(beat_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Register index for a header bit, or -1 when the bit carries a zero word.
  function automatic int reg_of_bit(input int b);
    case (b)
      2: return 0;   3: return 1;   4: return 2;   6: return 3;
      8: return 4;   10: return 5;  11: return 6;  12: return 7;
      14: return 8;  19: return 9;  20: return 10; 21: return 11;
      30: return 12;
      default: return -1;
    endcase
  endfunction

  function automatic logic [32*13-1:0] rand_snap();
    logic [32*13-1:0] s;
    for (int k = 0; k < 13; k++) s[32*k +: 32] = $urandom;
    return s;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_valid"}, 64'(wr_valid), 64'd0);
    check({tag, "_busy"},  64'(busy),     64'd0);
    check({tag, "_done"},  64'(done),     64'd0);
    check({tag, "_abrt"},  64'(aborted),  64'd0);
    check({tag, "_last"},  64'(wr_last),  64'd0);
    check({tag, "_addr"},  64'(wr_addr),  64'd0);
    check({tag, "_data"},  64'(wr_data),  64'd0);
    check({tag, "_cnt"},   64'(beat_cnt), 64'd0);
  endtask

  // mode: 0 ready always, 1 ready toggles 1/0, 2 random ready.
  // abort_at: beat index during which abort is held, -1 for none.
  task automatic run_desc(input logic [31:0] hdr, input logic [31:0] base,
                          input int mode, input int abort_at);
    logic [31:0]      ea[$];
    logic [31:0]      ed[$];
    logic             el[$];
    logic [32*13-1:0] snap0;
    logic [31:0]      a0;
    int               n, idx, cyc, rk;
    bit               fin, rdy, ab;

    snap0 = rand_snap();
    a0    = base & 32'hFFFF_FFFC;
    ea.push_back(a0);
    ed.push_back(hdr);
    for (int b = 1; b < 32; b++) begin
      if (hdr[b]) begin
        rk = reg_of_bit(b);
        ea.push_back(a0 + 32'(4 * ea.size()));
        ed.push_back(rk < 0 ? 32'h0 : snap0[32*rk +: 32]);
      end
    end
    n = ed.size();
    for (int i = 0; i < n; i++) el.push_back(i == n - 1);

    header_in    = hdr;
    base_addr    = base;
    reg_snapshot = snap0;
    start        = 1'b1;
    step();
    start = 1'b0;
    check("start_busy",  64'(busy),     64'd1);
    check("start_cnt",   64'(beat_cnt), 64'd0);

    idx = 0; cyc = 0; fin = 0;
    while (!fin && cyc < 300) begin
      cyc++;
      check("valid", 64'(wr_valid), 64'd1);
      check("addr",  64'(wr_addr),  64'(ea[idx]));
      check("data",  64'(wr_data),  64'(ed[idx]));
      check("last",  64'(wr_last),  64'(el[idx]));
      check("cnt",   64'(beat_cnt), 64'(idx));
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = cyc[0];
        default: rdy = ($urandom_range(0, 2) != 0);
      endcase
      ab           = (idx == abort_at);
      wr_ready     = rdy;
      abort        = ab;
      header_in    = $urandom;
      base_addr    = $urandom;
      reg_snapshot = rand_snap();
      start        = ($urandom_range(0, 3) == 0);
      step();
      start = 1'b0;
      abort = 1'b0;
      if (ab) begin
        check("ab_pulse", 64'(aborted),  64'd1);
        check("ab_busy",  64'(busy),     64'd0);
        check("ab_valid", 64'(wr_valid), 64'd0);
        check("ab_done",  64'(done),     64'd0);
        check("ab_cnt",   64'(beat_cnt), 64'(idx + int'(rdy)));
        step();
        check("ab_pulse1", 64'(aborted), 64'd0);
        check("ab_done1",  64'(done),    64'd0);
        check("ab_idle",   64'(busy),    64'd0);
        fin = 1;
      end else if (rdy) begin
        idx++;
        if (idx == n) begin
          check("done_pulse", 64'(done),     64'd1);
          check("done_busy",  64'(busy),     64'd1);
          check("done_valid", 64'(wr_valid), 64'd0);
          check("done_cnt",   64'(beat_cnt), 64'(n));
          wr_ready = 1'b0;
          step();
          check("post_done", 64'(done),     64'd0);
          check("post_busy", 64'(busy),     64'd0);
          check("post_cnt",  64'(beat_cnt), 64'(n));
          fin = 1;
        end
      end
    end
    if (!fin) check("timeout", 64'd1, 64'd0);
    wr_ready = 1'b0;
  endtask

  initial begin
    resetn       = 1'b0;
    start        = 1'b0;
    abort        = 1'b0;
    header_in    = '0;
    base_addr    = '0;
    reg_snapshot = '0;
    wr_ready     = 1'b0;
    #3;
    check_idle_outputs("rst");
    #10 resetn = 1'b1;
    step();

    // Abort while idle has no effect.
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("idle_abort", 64'(aborted), 64'd0);

    run_desc(32'h0000_000C, 32'h0000_1000, 0, -1);
    run_desc(32'h4000_0011, 32'h0000_2000, 0, -1);
    run_desc(32'h0000_0022, 32'h0000_3003, 0, -1);
    run_desc(32'h0000_0001, 32'h0000_4000, 0, -1);
    run_desc(32'h0000_0118, 32'hFFFF_FFF8, 1, -1);
    run_desc(32'hFFFF_FFFF, 32'hFFFF_FF80, 2, -1);
    run_desc(32'h7FFF_FFFE, 32'h0000_5000, 0, 2);
    run_desc(32'h0000_0000, 32'h0000_6000, 2, -1);

    for (int t = 0; t < 30; t++)
      run_desc($urandom, $urandom, 2, ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 5)) : -1);

    // Reset in the middle of the payload phase.
    header_in    = 32'hFFFF_FFFE;
    base_addr    = 32'h0000_8000;
    reg_snapshot = rand_snap();
    start        = 1'b1;
    step();
    start    = 1'b0;
    wr_ready = 1'b1;
    step();
    step();
    check("pre_rst_busy", 64'(busy), 64'd1);
    resetn = 1'b0;
    #1;
    check_idle_outputs("midrst");
    #2 resetn = 1'b1;
    wr_ready = 1'b0;
    step();
    run_desc(32'h0010_4050, 32'h0000_9000, 2, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
